// File: rtl/lsu_master.sv
// lsu_master: load/store initiator between the core and a word-wide,
// big-endian data memory. Sub-word loads extract and extend the addressed
// lane; sub-word stores use read-modify-write. Completion is a one-cycle
// done pulse.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned half/word requests complete immediately with
//               misalign=1 and no memory access.
//   undefined - misalign is constant 0; low address bits are forced to the
//               access alignment and the access proceeds normally.
module lsu_master #(
   parameter int unsigned HOLD_CYCLES = 0,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              misalign,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic                sign_q, sign_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         word_q, word_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                misalign_q, misalign_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                mis_w;
   logic                last_w;

   // Pick the addressed lane (big-endian) and extend it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                                input logic sx, input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      h = off[1] ? w[15:0] : w[31:16];
      if (sz[1])      return w;
      else if (sz[0]) return {{16{sx & h[15]}}, h};
      else            return {{24{sx & b[7]}}, b};
   endfunction

   // Replace the addressed lane of the captured word with right-justified store data.
   function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                               input logic [1:0] sz, input logic [1:0] off);
      logic [31:0] r;
      r = w;
      if (sz[1]) begin
         r = d;
      end else if (sz[0]) begin
         if (off[1]) r[15:0]  = d[15:0];
         else        r[31:16] = d[15:0];
      end else begin
         case (off)
            2'd0:    r[31:24] = d[7:0];
            2'd1:    r[23:16] = d[7:0];
            2'd2:    r[15:8]  = d[7:0];
            default: r[7:0]   = d[7:0];
         endcase
      end
      return r;
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   assign mis_w = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
   assign mis_w = 1'b0;
`endif

   assign last_w = (cnt_q == CNT_W'(HOLD_CYCLES));

   // Next-state and operand/result register updates.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d    = state_q;
      we_d       = we_q;
      size_d     = size_q;
      sign_d     = sign_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      word_d     = word_q;
      rdata_d    = rdata_q;
      misalign_d = misalign_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (req) begin
               we_d       = we;
               size_d     = size;
               sign_d     = sign_ext;
               addr_d     = addr;
               wdata_d    = wdata;
               misalign_d = mis_w;
               if (mis_w)                 state_d = S_DONE;
               else if (!we || !size[1])  state_d = S_RD;
               else                       state_d = S_WR;
            end
         end
         S_RD: begin
            if (last_w) begin
               cnt_d  = '0;
               word_d = mem_rdata;
               if (!we_q) begin
                  rdata_d = load_extract(mem_rdata, size_q, sign_q, addr_q[1:0]);
                  state_d = S_DONE;
               end else begin
                  state_d = S_WR;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WR: begin
            if (last_w) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any access immediately.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q    <= S_IDLE;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         sign_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         word_q     <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         size_q     <= size_d;
         sign_q     <= sign_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         word_q     <= word_d;
         rdata_q    <= rdata_d;
         misalign_q <= misalign_d;
         cnt_q      <= cnt_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign mem_read  = (state_q == S_RD);
   assign mem_write = (state_q == S_WR);
   assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata = store_merge(word_q, wdata_q, size_q, addr_q[1:0]);
   assign rdata     = rdata_q;
   assign misalign  = misalign_q;

endmodule

// File: tb/tb_lsu_master.sv
// tb_lsu_master: directed and randomized checks of lsu_master against a
// byte-addressed big-endian reference memory.
module tb_lsu_master;

   logic        clk = 1'b0;
   logic        rst, req, req1, we, sign_ext;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic        busy, done, misalign, mem_write, mem_read;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic        busy1, done1, misalign1, mem_write1, mem_read1;
   logic [31:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;

   logic [31:0] mem  [0:255];
   logic [31:0] mem1 [0:255];
   logic        bd_we;
   logic [7:0]  bd_idx;
   logic [31:0] bd_data;

   logic [7:0]  ref_b [0:1023];
   logic [31:0] last_rd;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   lsu_master #(.HOLD_CYCLES(0), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
      .misalign(misalign), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata));

   lsu_master #(.HOLD_CYCLES(2), .ADDR_W(32)) dut_hold (
      .clk(clk), .rst(rst), .req(req1), .we(we), .size(size), .sign_ext(sign_ext),
      .addr(addr), .wdata(wdata), .busy(busy1), .done(done1), .rdata(rdata1),
      .misalign(misalign1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_write(mem_write1), .mem_read(mem_read1), .mem_rdata(mem_rdata1));

   assign mem_rdata  = mem[mem_addr[9:2]];
   assign mem_rdata1 = mem1[mem_addr1[9:2]];

   // Word memories: commit on rising edge; backdoor preload for dut memory.
   always @(posedge clk) begin
      if (mem_write)  mem[mem_addr[9:2]] <= mem_wdata;
      else if (bd_we) mem[bd_idx]        <= bd_data;
   end
   always @(posedge clk) begin
      if (mem_write1) mem1[mem_addr1[9:2]] <= mem_wdata1;
   end

   // ---------------- reference model (byte-addressed, big-endian) ----------------
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic int eff_addr(input logic [1:0] sz, input logic [31:0] a);
      int n = nbytes(sz);
      return int'(a[9:0]) / n * n;
   endfunction

   function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
      return (int'(a[9:0]) % nbytes(sz)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
      int          n  = nbytes(sz);
      int          ea = eff_addr(sz, a);
      logic [31:0] v  = 32'd0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_b[ea + i]);
      if (sx && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (sx && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      int n  = nbytes(sz);
      int ea = eff_addr(sz, a);
      for (int i = 0; i < n; i++) ref_b[ea + i] = 8'(d >> (8 * (n - 1 - i)));
   endtask

   function automatic logic [31:0] ref_word(input int a);
      int b = a / 4 * 4;
      return {ref_b[b], ref_b[b + 1], ref_b[b + 2], ref_b[b + 3]};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic set_word(input logic [31:0] a, input logic [31:0] w);
      @(negedge clk);
      bd_we = 1'b1; bd_idx = a[9:2]; bd_data = w;
      @(negedge clk);
      bd_we = 1'b0;
      for (int i = 0; i < 4; i++) ref_b[int'(a[9:2]) * 4 + i] = 8'(w >> (24 - 8 * i));
   endtask

   // Issue one request to dut and observe it until done (bounded).
   task automatic run_op(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int nrd, output int nwr,
                         output logic [31:0] rd, output logic mis, output logic [31:0] wd,
                         output logic addr_ok, output logic pulse_ok);
      @(negedge clk);
      we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      lat = 0; nrd = 0; nwr = 0; addr_ok = 1'b1; rd = rdata; mis = 1'b0; wd = 32'd0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         @(negedge clk);
         if (mem_read) nrd++;
         if (mem_write) begin nwr++; wd = mem_wdata; end
         if (mem_addr !== {a[31:2], 2'b00}) addr_ok = 1'b0;
         if (done) begin lat = c; rd = rdata; mis = misalign; end
      end
      @(negedge clk);
      pulse_ok = (done === 1'b0) && (rdata === rd);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1; req = 1'b0; req1 = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
      addr = '0; wdata = '0; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
      #12;
      checks++; if ({busy, done, misalign, mem_read, mem_write} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, misalign, mem_read, mem_write}); end
      checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
      checks++; if ({mem_addr, mem_wdata} !== 64'd0) begin
         errors++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_addr, mem_wdata); end
      @(negedge clk);
      rst = 1'b0;
      last_rd = 32'd0;
   endtask

   task automatic test_byte_load;
      int lat, nrd, nwr; logic [31:0] rd, wd; logic mis, aok, pok;
      set_word(32'h40, 32'h1122_3344);
      run_op(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, lat, nrd, nwr, rd, mis, wd, aok, pok);
      checks++; if (rd !== 32'h0000_0022) begin errors++; $display("FAIL byte_load_data: got %h expected 00000022", rd); end
      checks++; if ({lat, nrd, nwr} !== {32'd2, 32'd1, 32'd0}) begin
         errors++; $display("FAIL byte_load_timing: got lat=%0d rd=%0d wr=%0d expected 2/1/0", lat, nrd, nwr); end
      checks++; if ({aok, pok} !== 2'b11) begin
         errors++; $display("FAIL byte_load_addr_pulse: got %b expected 11", {aok, pok}); end
      last_rd = rd;
   endtask

   task automatic test_half_load;
      int lat, nrd, nwr; logic [31:0] rd, wd; logic mis, aok, pok;
      set_word(32'h40, 32'h1122_F344);
      run_op(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, lat, nrd, nwr, rd, mis, wd, aok, pok);
      checks++; if (rd !== 32'hFFFF_F344) begin errors++; $display("FAIL half_load_signed: got %h expected FFFFF344", rd); end
      run_op(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, lat, nrd, nwr, rd, mis, wd, aok, pok);
      checks++; if (rd !== 32'h0000_F344) begin errors++; $display("FAIL half_load_unsigned: got %h expected 0000F344", rd); end
      last_rd = rd;
   endtask

   task automatic test_byte_store;
      int lat, nrd, nwr; logic [31:0] rd, wd; logic mis, aok, pok;
      set_word(32'h40, 32'h1122_3344);
      run_op(1'b1, 2'b00, 1'b0, 32'h42, 32'h0000_00AB, lat, nrd, nwr, rd, mis, wd, aok, pok);
      checks++; if (wd !== 32'h1122_AB44) begin errors++; $display("FAIL byte_store_wdata: got %h expected 1122AB44", wd); end
      checks++; if ({lat, nrd, nwr} !== {32'd3, 32'd1, 32'd1}) begin
         errors++; $display("FAIL byte_store_timing: got lat=%0d rd=%0d wr=%0d expected 3/1/1", lat, nrd, nwr); end
      checks++; if (mem[8'h10] !== 32'h1122_AB44) begin errors++; $display("FAIL byte_store_mem: got %h expected 1122AB44", mem[8'h10]); end
      checks++; if (rd !== last_rd) begin errors++; $display("FAIL byte_store_rdata_held: got %h expected %h", rd, last_rd); end
      ref_store(2'b00, 32'h42, 32'hAB);
   endtask

   task automatic test_word_store;
      int lat, nrd, nwr; logic [31:0] rd, wd; logic mis, aok, pok;
      run_op(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, lat, nrd, nwr, rd, mis, wd, aok, pok);
      checks++; if ({lat, nrd, nwr} !== {32'd2, 32'd0, 32'd1}) begin
         errors++; $display("FAIL word_store_timing: got lat=%0d rd=%0d wr=%0d expected 2/0/1", lat, nrd, nwr); end
      checks++; if (mem[8'h10] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_store_mem: got %h expected DEADBEEF", mem[8'h10]); end
      ref_store(2'b10, 32'h40, 32'hDEAD_BEEF);
   endtask

   task automatic test_busy_ignore;
      int ndone = 0, nrd = 0;
      set_word(32'h44, 32'h0);
      @(negedge clk);
      we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h44; wdata = 32'h0102_0304; req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) begin req = 1'b1; we = 1'b0; addr = 32'h48; end
         if (c == 2) req = 1'b0;
         if (done) ndone++;
         if (mem_read) nrd++;
      end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_ignore_done_count: got %0d expected 1", ndone); end
      checks++; if (nrd !== 0) begin errors++; $display("FAIL busy_ignore_no_read: got %0d expected 0", nrd); end
      checks++; if (mem[8'h11] !== 32'h0102_0304) begin errors++; $display("FAIL busy_ignore_mem: got %h expected 01020304", mem[8'h11]); end
      ref_store(2'b10, 32'h44, 32'h0102_0304);
   endtask

   task automatic test_misalign;
      int lat, nrd, nwr; logic [31:0] rd, wd; logic mis, aok, pok;
      run_op(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, lat, nrd, nwr, rd, mis, wd, aok, pok);
`ifdef LSU_MISALIGN_TRAP_EN
      checks++; if ({lat, nrd, nwr, 31'd0, mis} !== {32'd1, 32'd0, 32'd0, 32'd1}) begin
         errors++; $display("FAIL misalign_trap: got lat=%0d rd=%0d wr=%0d mis=%b expected 1/0/0/1", lat, nrd, nwr, mis); end
      checks++; if (rd !== last_rd) begin errors++; $display("FAIL misalign_rdata_held: got %h expected %h", rd, last_rd); end
`else
      checks++; if ({lat, nrd, nwr, 31'd0, mis} !== {32'd2, 32'd1, 32'd0, 32'd0}) begin
         errors++; $display("FAIL misalign_forced: got lat=%0d rd=%0d wr=%0d mis=%b expected 2/1/0/0", lat, nrd, nwr, mis); end
      checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL misalign_forced_data: got %h expected DEADBEEF", rd); end
      last_rd = rd;
`endif
   endtask

   task automatic test_reset_mid_write;
      int lat, nrd, nwr; logic [31:0] rd, wd; logic mis, aok, pok;
      set_word(32'h80, 32'h5566_7788);
      @(negedge clk);
      we = 1'b1; size = 2'b10; addr = 32'h80; wdata = 32'h9999_9999; req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rst_mid_in_wr: got %b expected 1", mem_write); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({mem_write, busy} !== 2'b00) begin
         errors++; $display("FAIL rst_mid_drop: got wr=%b busy=%b expected 0/0", mem_write, busy); end
      @(negedge clk);
      rst = 1'b0;
      last_rd = 32'd0;
      checks++; if (mem[8'h20] !== 32'h5566_7788) begin errors++; $display("FAIL rst_mid_mem: got %h expected 55667788", mem[8'h20]); end
      run_op(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, lat, nrd, nwr, rd, mis, wd, aok, pok);
      checks++; if ({lat, rd} !== {32'd2, 32'h5566_7788}) begin
         errors++; $display("FAIL rst_mid_recover: got lat=%0d data=%h expected 2/55667788", lat, rd); end
      last_rd = rd;
   endtask

   task automatic test_random;
      int lat, nrd, nwr, elat, erd, ewr; logic [31:0] rd, wd, erdata, a, d; logic mis, emis, aok, pok, w, sx;
      logic [1:0] sz;
      for (int i = 0; i < 64; i++) set_word(32'(i * 4), $urandom);
      for (int i = 0; i < 80; i++) begin
         w = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); sx = 1'($urandom_range(0, 1));
         a = 32'($urandom_range(0, 255)); d = $urandom;
         emis = ref_mis(sz, a);
         erdata = last_rd;
         if (emis)          begin elat = 1; erd = 0; ewr = 0; end
         else if (!w)       begin elat = 2; erd = 1; ewr = 0; erdata = ref_load(sz, sx, a); end
         else if (sz[1])    begin elat = 2; erd = 0; ewr = 1; end
         else               begin elat = 3; erd = 1; ewr = 1; end
         if (w && !emis) ref_store(sz, a, d);
         run_op(w, sz, sx, a, d, lat, nrd, nwr, rd, mis, wd, aok, pok);
         checks++; if ({lat, nrd, nwr, 31'd0, mis} !== {elat, erd, ewr, 31'd0, emis}) begin
            errors++; $display("FAIL rand_timing[%0d]: got lat=%0d rd=%0d wr=%0d mis=%b expected %0d/%0d/%0d/%b",
                               i, lat, nrd, nwr, mis, elat, erd, ewr, emis); end
         checks++; if (rd !== erdata) begin
            errors++; $display("FAIL rand_rdata[%0d]: we=%b sz=%0d addr=%h got %h expected %h", i, w, sz, a, rd, erdata); end
         checks++; if (mem[a[9:2]] !== ref_word(int'(a))) begin
            errors++; $display("FAIL rand_mem[%0d]: addr=%h got %h expected %h", i, a, mem[a[9:2]], ref_word(int'(a))); end
         checks++; if ({aok, pok} !== 2'b11) begin
            errors++; $display("FAIL rand_addr_pulse[%0d]: got %b expected 11", i, {aok, pok}); end
         last_rd = erdata;
      end
   endtask

   task automatic test_hold;
      int lat, nwr, nrd;
      logic [31:0] rd;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         we = (k == 0); size = (k == 0) ? 2'b10 : 2'b00; sign_ext = 1'b1;
         addr = (k == 0) ? 32'h40 : 32'h43; wdata = 32'hA5A5_A5A5; req1 = 1'b1;
         @(posedge clk);
         #1 req1 = 1'b0;
         lat = 0; nwr = 0; nrd = 0; rd = 32'd0;
         for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (mem_write1) nwr++;
            if (mem_read1) nrd++;
            if (done1) begin lat = c; rd = rdata1; end
         end
         if (k == 0) begin
            checks++; if ({lat, nrd, nwr} !== {32'd4, 32'd0, 32'd3}) begin
               errors++; $display("FAIL hold_word_store: got lat=%0d rd=%0d wr=%0d expected 4/0/3", lat, nrd, nwr); end
         end else begin
            checks++; if ({lat, nrd, nwr, rd} !== {32'd4, 32'd3, 32'd0, 32'hFFFF_FFA5}) begin
               errors++; $display("FAIL hold_byte_load: got lat=%0d rd=%0d wr=%0d data=%h expected 4/3/0/FFFFFFA5",
                                  lat, nrd, nwr, rd); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_byte_load;
      test_half_load;
      test_byte_store;
      test_word_store;
      test_busy_ignore;
      test_misalign;
      test_reset_mid_write;
      test_random;
      test_hold;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
